seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Executes the existing 4-bit operation set in one registered cycle.
- Adds iterative multiply, unsigned divide and unsigned remainder behind a start/ready/valid handshake.
- Sits in the EX stage of the upcoming multi-cycle CPU; the control unit stalls on ready_o.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/seq_alu_muldiv.sv | 119 +++++++++++
 rtl/seq_alu.sv | 165 ++++++++++++++++
 tb/tb_seq_alu.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu: op codes, FSM states and the iterative engine's mode select.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_LUI  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;
  localparam logic [3:0] OP_SRAV = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REMU = 4'd14;
  localparam logic [3:0] OP_MUL  = 4'd15;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_REM} md_mode_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative engine: shift-add multiply (LSB first) and restoring divide (MSB first), WIDTH steps.
// With SEQ_ALU_OVERFLOW_EN the accumulator is 2*WIDTH wide and o_ovf flags signed-product overflow.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  md_mode_t         i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
`ifdef SEQ_ALU_OVERFLOW_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
`ifdef SEQ_ALU_OVERFLOW_EN
  localparam int AW = 2 * WIDTH;
`else
  localparam int AW = WIDTH;
`endif

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  md_mode_t         r_mode;
  logic [AW-1:0]    r_acc;
  logic [AW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_shift;   // multiplier for mul, dividend turning into quotient for div/rem
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;

  logic [AW-1:0]    w_acc_next;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quot_next;
  logic [WIDTH-1:0] w_mul_res;

  assign w_acc_next  = r_shift[0] ? r_acc + r_mcand : r_acc;
  assign w_trial     = {r_rem, r_shift[WIDTH-1]};
  assign w_diff      = w_trial - {1'b0, r_divisor};
  assign w_ge        = ~w_diff[WIDTH];
  assign w_rem_next  = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quot_next = {r_shift[WIDTH-2:0], w_ge};

`ifdef SEQ_ALU_OVERFLOW_EN
  logic [WIDTH-1:0] r_a;
  logic [AW-1:0]    w_sprod;
  logic [WIDTH:0]   w_sprod_hi;

  // Unsigned product minus the sign-bit weights of each operand is the signed product.
  assign w_sprod    = w_acc_next - (r_a[WIDTH-1] ? {r_divisor, {WIDTH{1'b0}}} : '0)
                                 - (r_divisor[WIDTH-1] ? {r_a, {WIDTH{1'b0}}} : '0);
  assign w_sprod_hi = w_sprod[AW-1:WIDTH-1];
  assign w_mul_res  = w_sprod[WIDTH-1:0];
  assign o_ovf      = (r_mode == MD_MUL) && (|w_sprod_hi) && !(&w_sprod_hi);
`else
  assign w_mul_res  = w_acc_next;
`endif

  // o_done/o_result describe the step retiring on the coming edge.
  assign o_done = r_busy && (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    o_result = w_rem_next;
    case (r_mode)
      MD_MUL:  o_result = w_mul_res;
      MD_DIV:  o_result = w_quot_next;
      default: o_result = w_rem_next;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_mode    <= MD_MUL;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_shift   <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
`ifdef SEQ_ALU_OVERFLOW_EN
      r_a       <= '0;
`endif
    end else if (i_start) begin
      r_busy    <= 1'b1;
      r_cnt     <= '0;
      r_mode    <= i_mode;
      r_acc     <= '0;
      r_mcand   <= AW'(i_b);
      r_shift   <= i_a;
      r_rem     <= '0;
      r_divisor <= i_b;
`ifdef SEQ_ALU_OVERFLOW_EN
      r_a       <= i_a;
`endif
    end else if (r_busy) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_mode == MD_MUL) begin
        r_acc   <= w_acc_next;
        r_mcand <= r_mcand << 1;
        r_shift <= r_shift >> 1;
      end else begin
        r_rem   <= w_rem_next;
        r_shift <= w_quot_next;
      end
      if (o_done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered single-cycle ALU ops plus iterative mul/divu/remu behind start/ready/valid.
// Define SEQ_ALU_OVERFLOW_EN to add the ovf_o signed-overflow flag.
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
`ifdef SEQ_ALU_OVERFLOW_EN
  output logic             ovf_o,
`endif
  output state_t           dbg_state_o
);

  // Handshake: a request transfers on a rising edge with start_i && ready_o; ready_o is high only
  // in IDLE and requests at other times are dropped. valid_o pulses for one cycle and
  // result_o/zero_o hold their value until the next pulse.
  state_t           r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_zero;
  logic             w_md_go;
  logic             w_md_start;
  logic             w_md_done;
  md_mode_t         w_md_mode;
  logic [WIDTH-1:0] w_md_result;

`ifdef SEQ_ALU_OVERFLOW_EN
  logic             r_ovf;
  logic             w_sc_ovf;
  logic             w_md_ovf;
`endif

  assign w_add      = src1_i + src2_i;
  assign w_sub      = src1_i - src2_i;
  // Divide by zero is answered directly by the single-cycle path.
  assign w_md_go    = (ctrl_i == OP_MUL) ||
                      (((ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU)) && (src2_i != '0));
  assign w_md_start = start_i && (r_state == IDLE) && w_md_go;
  assign w_md_mode  = (ctrl_i == OP_MUL) ? MD_MUL : (ctrl_i == OP_DIVU) ? MD_DIV : MD_REM;

  always_comb begin
    w_sc_result = '0;
    case (ctrl_i)
      OP_AND:  w_sc_result = src1_i & src2_i;
      OP_OR:   w_sc_result = src1_i | src2_i;
      OP_ADD:  w_sc_result = w_add;
      OP_LUI:  w_sc_result = src2_i << (WIDTH / 2);
      OP_SUB:  w_sc_result = w_sub;
      OP_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_SRA:  w_sc_result = $signed(src2_i) >>> shamt_i;
      OP_BNE:  w_sc_result = w_sub;
      OP_SRAV: w_sc_result = $signed(src2_i) >>> src1_i[SHW-1:0];
      OP_NOR:  w_sc_result = ~(src1_i | src2_i);
      OP_DIVU: w_sc_result = '1;
      OP_REMU: w_sc_result = src1_i;
      default: w_sc_result = '0;
    endcase
  end

  always_comb begin
    w_sc_zero = (w_sc_result == '0);
    case (ctrl_i)
      OP_SUB:  w_sc_zero = (w_sub == '0);
      OP_BNE:  w_sc_zero = (w_sub != '0);
      default: w_sc_zero = (w_sc_result == '0);
    endcase
  end

`ifdef SEQ_ALU_OVERFLOW_EN
  always_comb begin
    w_sc_ovf = 1'b0;
    case (ctrl_i)
      OP_ADD:         w_sc_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                                 (w_add[WIDTH-1] != src1_i[WIDTH-1]);
      OP_SUB, OP_BNE: w_sc_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                                 (w_sub[WIDTH-1] != src1_i[WIDTH-1]);
      default:        w_sc_ovf = 1'b0;
    endcase
  end

  assign ovf_o = r_ovf;
`endif

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .i_clk    (clk_i),
    .i_rst_n  (rst_i),
    .i_start  (w_md_start),
    .i_mode   (w_md_mode),
    .i_a      (src1_i),
    .i_b      (src2_i),
    .o_done   (w_md_done),
`ifdef SEQ_ALU_OVERFLOW_EN
    .o_ovf    (w_md_ovf),
`endif
    .o_result (w_md_result)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (w_md_go) begin
              r_state <= RUN;
            end else begin
              r_state  <= DONE;
              r_valid  <= 1'b1;
              r_result <= w_sc_result;
              r_zero   <= w_sc_zero;
`ifdef SEQ_ALU_OVERFLOW_EN
              r_ovf    <= w_sc_ovf;
`endif
            end
          end
        end
        RUN: begin
          if (w_md_done) begin
            r_state  <= DONE;
            r_valid  <= 1'b1;
            r_result <= w_md_result;
            r_zero   <= (w_md_result == '0);
`ifdef SEQ_ALU_OVERFLOW_EN
            r_ovf    <= w_md_ovf;
`endif
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o     = (r_state == IDLE);
  assign valid_o     = r_valid;
  assign result_o    = r_result;
  assign zero_o      = r_zero;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases, random ops against a reference model, throughput.
// Define SEQ_ALU_OVERFLOW_EN for both bench and design to also check ovf_o.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W       = 32;
  localparam int SHW     = $clog2(W);
  localparam int TIMEOUT = 3 * W;

  typedef struct packed {
    logic         ovf;
    logic         zero;
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [3:0]     ctrl;
  logic [W-1:0]   src1;
  logic [W-1:0]   src2;
  logic [SHW-1:0] shamt;
  logic           ready;
  logic           valid;
  logic [W-1:0]   result;
  logic           zero;
  state_t         dbg_state;
`ifdef SEQ_ALU_OVERFLOW_EN
  logic           ovf;
`endif

  int     n_cmp  = 0;
  int     n_fail = 0;
  longint cyc    = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .ctrl_i      (ctrl),
    .src1_i      (src1),
    .src2_i      (src2),
    .shamt_i     (shamt),
    .ready_o     (ready),
    .valid_o     (valid),
    .result_o    (result),
    .zero_o      (zero),
`ifdef SEQ_ALU_OVERFLOW_EN
    .ovf_o       (ovf),
`endif
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [SHW-1:0] sh);
    exp_t e;
    logic [W:0] ext;
    logic signed [2*W-1:0] p;
    e.res = '0;
    e.ovf = 1'b0;
    e.lat = 1;
    case (c)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: begin
        e.res = a + b;
        ext   = {a[W-1], a} + {b[W-1], b};
        e.ovf = ext[W] ^ ext[W-1];
      end
      4'd3: e.res = b << (W / 2);
      4'd6, 4'd9: begin
        e.res = a - b;
        ext   = {a[W-1], a} - {b[W-1], b};
        e.ovf = ext[W] ^ ext[W-1];
      end
      4'd7:  e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'd8:  e.res = $signed(b) >>> sh;
      4'd11: e.res = $signed(b) >>> a[SHW-1:0];
      4'd12: e.res = ~(a | b);
      4'd13: if (b == 0) e.res = '1; else begin e.res = a / b; e.lat = W + 1; end
      4'd14: if (b == 0) e.res = a;  else begin e.res = a % b; e.lat = W + 1; end
      4'd15: begin
        p     = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        e.res = p[W-1:0];
        e.ovf = (p != {{W{p[W-1]}}, p[W-1:0]});
        e.lat = W + 1;
      end
      default: e.res = '0;
    endcase
    if (c == 4'd6)      e.zero = (a == b);
    else if (c == 4'd9) e.zero = (a != b);
    else                e.zero = (e.res == 0);
    return e;
  endfunction

  // ---------------- driver ----------------
  // Issues one op when ready, optionally re-asserts start at latency step `poke`, then waits for
  // valid. lat = cycles from accept edge until valid is seen (1 = seen right after accept), -1 on timeout.
  task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SHW-1:0] sh, input int poke,
                        output logic [W-1:0] res, output logic z, output logic ov,
                        output int lat, output longint acc_cyc);
    int wait_n;
    wait_n = 0;
    @(negedge clk);
    while (!ready && wait_n < TIMEOUT) begin
      @(negedge clk);
      wait_n++;
    end
    ctrl  = c;
    src1  = a;
    src2  = b;
    shamt = sh;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start   = 1'b0;
    ctrl    = 4'($urandom);
    src1    = $urandom;
    src2    = $urandom;
    shamt   = SHW'($urandom);
    lat     = 1;
    while (!valid && lat <= TIMEOUT) begin
      start = (lat == poke);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    if (lat > TIMEOUT) lat = -1;
    res = result;
    z   = zero;
`ifdef SEQ_ALU_OVERFLOW_EN
    ov  = ovf;
`else
    ov  = 1'b0;
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    ctrl  = '0;
    src1  = '0;
    src2  = '0;
    shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_cmp++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    n_cmp++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b expected 0", zero); end
    n_cmp++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
`ifdef SEQ_ALU_OVERFLOW_EN
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_mul();
    logic [W-1:0] r;
    logic z, ov, seen;
    int lat;
    longint ac;
    @(negedge clk);
    ctrl = 4'd15; src1 = 7; src2 = 9; shamt = '0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", ready); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", valid); end
    n_cmp++; if (result !== '0) begin n_fail++; $display("FAIL midrst_result: got %h expected 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_valid: got %b expected 0", seen); end
    n_cmp++; if (result !== '0) begin n_fail++; $display("FAIL midrst_result_after: got %h expected 0", result); end
    run_op(4'd2, 3, 4, '0, 0, r, z, ov, lat, ac);
    n_cmp++; if (r !== 32'd7) begin n_fail++; $display("FAIL midrst_add_res: got %h expected 7", r); end
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL midrst_add_lat: got %0d expected 1", lat); end
  endtask

  task automatic test_branch();
    logic [3:0]   c_t [3] = '{4'd6, 4'd9, 4'd9};
    logic [W-1:0] b_t [3] = '{32'd5, 32'd5, 32'd6};
    logic [W-1:0] r_t [3] = '{32'h0, 32'h0, 32'hFFFF_FFFF};
    logic         z_t [3] = '{1'b1, 1'b0, 1'b1};
    logic [W-1:0] r;
    logic z, ov;
    int lat;
    longint ac;
    for (int i = 0; i < 3; i++) begin
      run_op(c_t[i], 32'd5, b_t[i], '0, 0, r, z, ov, lat, ac);
      n_cmp++; if (r !== r_t[i]) begin n_fail++; $display("FAIL branch_res[%0d]: got %h expected %h", i, r, r_t[i]); end
      n_cmp++; if (z !== z_t[i]) begin n_fail++; $display("FAIL branch_zero[%0d]: got %b expected %b", i, z, z_t[i]); end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] r;
    logic z, ov, seen;
    int lat;
    longint ac;
    run_op(4'd15, 32'hFFFF_FFFF, 32'd3, '0, 10, r, z, ov, lat, ac);
    n_cmp++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL mul_res: got %h expected fffffffd", r); end
    n_cmp++; if (lat != W + 1) begin n_fail++; $display("FAIL mul_lat: got %0d expected %0d", lat, W + 1); end
    n_cmp++; if (z !== 1'b0) begin n_fail++; $display("FAIL mul_zero: got %b expected 0", z); end
`ifdef SEQ_ALU_OVERFLOW_EN
    n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL mul_ovf: got %b expected 0", ov); end
`endif
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mul_poke_ignored: got %b expected 0", seen); end
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready_after: got %b expected 1", ready); end
  endtask

  task automatic test_div();
    logic [3:0]   c_t [4] = '{4'd13, 4'd14, 4'd13, 4'd14};
    logic [W-1:0] b_t [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [W-1:0] r_t [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd100};
    int           l_t [4] = '{W + 1, W + 1, 1, 1};
    logic [W-1:0] r;
    logic z, ov;
    int lat;
    longint ac;
    for (int i = 0; i < 4; i++) begin
      run_op(c_t[i], 32'd100, b_t[i], '0, 0, r, z, ov, lat, ac);
      n_cmp++; if (r !== r_t[i]) begin n_fail++; $display("FAIL div_res[%0d]: got %h expected %h", i, r, r_t[i]); end
      n_cmp++; if (lat != l_t[i]) begin n_fail++; $display("FAIL div_lat[%0d]: got %0d expected %0d", i, lat, l_t[i]); end
    end
  endtask

  task automatic test_shift_lui();
    logic [3:0]   c_t [4] = '{4'd8, 4'd11, 4'd3, 4'd5};
    logic [W-1:0] a_t [4] = '{32'h0, 32'h24, 32'h0, 32'h1234};
    logic [W-1:0] b_t [4] = '{32'h8000_0000, 32'h8000_0000, 32'h1234, 32'h5678};
    logic [W-1:0] r_t [4] = '{32'hF800_0000, 32'hF800_0000, 32'h1234_0000, 32'h0};
    logic         z_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] r;
    logic z, ov;
    int lat;
    longint ac;
    for (int i = 0; i < 4; i++) begin
      run_op(c_t[i], a_t[i], b_t[i], (i == 0) ? SHW'(4) : SHW'(17), 0, r, z, ov, lat, ac);
      n_cmp++; if (r !== r_t[i]) begin n_fail++; $display("FAIL shift_res[%0d]: got %h expected %h", i, r, r_t[i]); end
      n_cmp++; if (z !== z_t[i]) begin n_fail++; $display("FAIL shift_zero[%0d]: got %b expected %b", i, z, z_t[i]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r;
    logic [3:0] c;
    logic [SHW-1:0] sh;
    logic z, ov;
    int lat;
    longint ac;
    exp_t e;
    for (int i = 0; i < 80; i++) begin
      c  = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      sh = SHW'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = a;
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        default: ;
      endcase
      e = model(c, a, b, sh);
      run_op(c, a, b, sh, 0, r, z, ov, lat, ac);
      n_cmp++; if (r !== e.res) begin n_fail++; $display("FAIL rand_res[%0d] op %0d a %h b %h: got %h expected %h", i, c, a, b, r, e.res); end
      n_cmp++; if (z !== e.zero) begin n_fail++; $display("FAIL rand_zero[%0d] op %0d: got %b expected %b", i, c, z, e.zero); end
      n_cmp++; if (lat != e.lat) begin n_fail++; $display("FAIL rand_lat[%0d] op %0d: got %0d expected %0d", i, c, lat, e.lat); end
`ifdef SEQ_ALU_OVERFLOW_EN
      n_cmp++; if (ov !== e.ovf) begin n_fail++; $display("FAIL rand_ovf[%0d] op %0d a %h b %h: got %b expected %b", i, c, a, b, ov, e.ovf); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] c_t [6] = '{4'd2, 4'd0, 4'd15, 4'd12, 4'd7, 4'd13};
    logic [W-1:0] a, b, r;
    logic z, ov;
    int lat;
    int prev_lat;
    longint ac, prev_ac;
    exp_t e;
    prev_ac  = 0;
    prev_lat = 0;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = 32'($urandom_range(1, 1000));
      e = model(c_t[i], a, b, '0);
      run_op(c_t[i], a, b, '0, 0, r, z, ov, lat, ac);
      n_cmp++; if (r !== e.res) begin n_fail++; $display("FAIL b2b_res[%0d]: got %h expected %h", i, r, e.res); end
      if (i > 0) begin
        n_cmp++;
        if (ac - prev_ac != longint'(prev_lat + 1)) begin
          n_fail++;
          $display("FAIL b2b_gap[%0d]: got %0d expected %0d", i, ac - prev_ac, prev_lat + 1);
        end
      end
      prev_ac  = ac;
      prev_lat = e.lat;
    end
  endtask

`ifdef SEQ_ALU_OVERFLOW_EN
  task automatic test_overflow();
    logic [W-1:0] r;
    logic z, ov;
    int lat;
    longint ac;
    run_op(4'd2, 32'h7FFF_FFFF, 32'd1, '0, 0, r, z, ov, lat, ac);
    n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL ovf_add: got %b expected 1", ov); end
    n_cmp++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_add_res: got %h expected 80000000", r); end
    run_op(4'd15, 32'h0001_0000, 32'h0001_0000, '0, 0, r, z, ov, lat, ac);
    n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL ovf_mul: got %b expected 1", ov); end
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL ovf_mul_res: got %h expected 0", r); end
    n_cmp++; if (z !== 1'b1) begin n_fail++; $display("FAIL ovf_mul_zero: got %b expected 1", z); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_reset_mid_mul();
    test_branch();
    test_mul();
    test_div();
    test_shift_lui();
`ifdef SEQ_ALU_OVERFLOW_EN
    test_overflow();
`endif
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
